axi_adc_jesd204_align_ctrl: RTL

- Frame-alignment supervisor for the JESD204 ADC receive path, in the rx_clk domain beside the per-lane transceiver interface.
- Watches the per-octet start-of-frame indication (rx_sof), qualifies a stable SOF pattern and declares alignment lock.
- Gates sample validity to downstream ADC channel logic.
- Detects and counts alignment loss and sequences re-acquisition.

---
 rtl/axi_adc_jesd204_align_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/axi_adc_jesd204_align_ctrl.sv
// JESD204 ADC receive frame-alignment supervisor: qualifies a stable SOF
// pattern, gates sample validity, and detects and counts alignment loss.
module axi_adc_jesd204_align_ctrl #(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 3,
    parameter int unsigned SOF_TIMEOUT  = 64
) (
    input  logic       rx_clk,
    input  logic       rx_rstn,
    input  logic       enable,
    input  logic       relock,
    input  logic       loss_count_clr,
    input  logic [3:0] rx_sof,
    output logic [3:0] sof_pattern,
    output logic       align_locked,
    output logic       adc_valid,
    output logic       loss_event,
    output logic [7:0] loss_count,
    output logic [2:0] align_state
);

    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BW = $clog2(UNLOCK_COUNT + 1);
    localparam int unsigned TW = $clog2(SOF_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_VERIFY = 3'd2,
        S_LOCKED = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t        state;
    logic [3:0]    sof_q;
    logic [3:0]    cand;
    logic [GW-1:0] good_cnt;
    logic [BW-1:0] bad_cnt;
    logic [TW-1:0] gap_cnt;

    logic sof_zero_c;
    logic gap_timeout_c;
    logic mismatch_c;
    logic loss_c;

    assign align_state = 3'(state);

    // Beat classification against the registered SOF sample
    always_comb begin
        sof_zero_c    = (sof_q == 4'd0);
        gap_timeout_c = sof_zero_c && (gap_cnt == TW'(SOF_TIMEOUT - 1));
        mismatch_c    = !sof_zero_c && (sof_q != sof_pattern);
        loss_c        = 1'b0;
        if (enable && !relock) begin
            if (state == S_LOCKED)
                loss_c = gap_timeout_c || (mismatch_c && (UNLOCK_COUNT == 1));
            else if (state == S_HOLD)
                loss_c = gap_timeout_c ||
                         (mismatch_c && (bad_cnt == BW'(UNLOCK_COUNT - 1)));
        end
    end

    // Input sample stage gives the one-beat evaluation latency
    always_ff @(posedge rx_clk) begin
        if (!rx_rstn) sof_q <= 4'd0;
        else          sof_q <= rx_sof;
    end

    // Alignment state machine with registered outputs
    always_ff @(posedge rx_clk) begin
        if (!rx_rstn) begin
            state        <= S_IDLE;
            cand         <= 4'd0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
            gap_cnt      <= '0;
            sof_pattern  <= 4'd0;
            align_locked <= 1'b0;
            adc_valid    <= 1'b0;
            loss_event   <= 1'b0;
        end else begin
            loss_event <= 1'b0;
            if (!enable || relock || loss_c) begin
                state        <= enable ? S_SEARCH : S_IDLE;
                cand         <= 4'd0;
                good_cnt     <= '0;
                bad_cnt      <= '0;
                gap_cnt      <= '0;
                sof_pattern  <= 4'd0;
                align_locked <= 1'b0;
                adc_valid    <= 1'b0;
                loss_event   <= enable && !relock;
            end else begin
                case (state)
                    S_IDLE: begin
                        state   <= S_SEARCH;
                        gap_cnt <= '0;
                    end
                    S_SEARCH: begin
                        if (!sof_zero_c) begin
                            cand     <= sof_q;
                            good_cnt <= GW'(1);
                            gap_cnt  <= '0;
                            if (LOCK_COUNT == 1) begin
                                state        <= S_LOCKED;
                                sof_pattern  <= sof_q;
                                align_locked <= 1'b1;
                                adc_valid    <= 1'b1;
                            end else begin
                                state <= S_VERIFY;
                            end
                        end else if (gap_timeout_c) begin
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + TW'(1);
                        end
                    end
                    S_VERIFY: begin
                        if (!sof_zero_c) begin
                            gap_cnt <= '0;
                            if (sof_q == cand) begin
                                if (good_cnt == GW'(LOCK_COUNT - 1)) begin
                                    state        <= S_LOCKED;
                                    sof_pattern  <= cand;
                                    align_locked <= 1'b1;
                                    adc_valid    <= 1'b1;
                                    good_cnt     <= '0;
                                end else begin
                                    good_cnt <= good_cnt + GW'(1);
                                end
                            end else begin
                                cand     <= sof_q;
                                good_cnt <= GW'(1);
                            end
                        end else if (gap_timeout_c) begin
                            state    <= S_SEARCH;
                            gap_cnt  <= '0;
                            good_cnt <= '0;
                            cand     <= 4'd0;
                        end else begin
                            gap_cnt <= gap_cnt + TW'(1);
                        end
                    end
                    S_LOCKED: begin
                        if (sof_zero_c) begin
                            gap_cnt <= gap_cnt + TW'(1);
                        end else if (mismatch_c) begin
                            state     <= S_HOLD;
                            bad_cnt   <= BW'(1);
                            gap_cnt   <= '0;
                            adc_valid <= 1'b0;
                        end else begin
                            gap_cnt <= '0;
                        end
                    end
                    S_HOLD: begin
                        // Zero beats leave bad_cnt alone; only the gap timer runs
                        if (sof_zero_c) begin
                            gap_cnt <= gap_cnt + TW'(1);
                        end else if (mismatch_c) begin
                            bad_cnt <= bad_cnt + BW'(1);
                            gap_cnt <= '0;
                        end else begin
                            state     <= S_LOCKED;
                            bad_cnt   <= '0;
                            gap_cnt   <= '0;
                            adc_valid <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Saturating loss counter; clear takes precedence over a coincident loss
    always_ff @(posedge rx_clk) begin
        if (!rx_rstn)
            loss_count <= 8'd0;
        else if (loss_count_clr)
            loss_count <= 8'd0;
        else if (loss_c && (loss_count != 8'hFF))
            loss_count <= loss_count + 8'd1;
    end

endmodule
